// File: rtl/alub_fwd_stage.sv
// rtl/alub_fwd_stage.sv - ALU B-operand select with EX/MEM and MEM/WB forwarding into ID/EX; ALUB_FWD_STATS_EN adds forward counters
module alub_fwd_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic                  ALUBSrc,
  input  logic [XLEN-1:0]       ImmExt,
  input  logic [XLEN-1:0]       RUrs2,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic                  exmem_RUWr,
  input  logic [XLEN-1:0]       exmem_result,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic                  memwb_RUWr,
  input  logic [XLEN-1:0]       memwb_result,
  output logic [XLEN-1:0]       B,
  output logic [XLEN-1:0]       StoreData,
  output logic                  B_valid,
  output logic [1:0]            FwdSel,
  output logic [15:0]           fwd_ex_cnt,
  output logic [15:0]           fwd_wb_cnt
);

  localparam logic [1:0] SEL_REG = 2'd0;
  localparam logic [1:0] SEL_WB  = 2'd1;
  localparam logic [1:0] SEL_EX  = 2'd2;
  localparam logic [1:0] SEL_IMM = 2'd3;

  logic            ex_hit;
  logic            wb_hit;
  logic [XLEN-1:0] rs2val;
  logic [XLEN-1:0] bsel;
  logic [1:0]      fwdsel_d;
  logic            load_en;

  // Resolve rs2: EX/MEM holds the newest value so it beats MEM/WB; x0 never forwards
  always_comb begin
    ex_hit   = exmem_RUWr && (exmem_rd != '0) && (exmem_rd == rs2_addr);
    wb_hit   = memwb_RUWr && (memwb_rd != '0) && (memwb_rd == rs2_addr);
    rs2val   = RUrs2;
    fwdsel_d = SEL_REG;
    if (ex_hit) begin
      rs2val   = exmem_result;
      fwdsel_d = SEL_EX;
    end else if (wb_hit) begin
      rs2val   = memwb_result;
      fwdsel_d = SEL_WB;
    end
    bsel = rs2val;
    if (ALUBSrc) begin
      bsel     = ImmExt;
      fwdsel_d = SEL_IMM;
    end
  end

  assign load_en = !flush && !stall;

  // ID/EX boundary registers: rst > flush > stall > load
  always_ff @(posedge clk) begin
    if (rst) begin
      B         <= '0;
      StoreData <= '0;
      B_valid   <= 1'b0;
      FwdSel    <= SEL_REG;
    end else if (flush) begin
      B         <= '0;
      StoreData <= '0;
      B_valid   <= 1'b0;
      FwdSel    <= SEL_REG;
    end else if (!stall) begin
      B         <= bsel;
      StoreData <= rs2val;
      B_valid   <= in_valid;
      FwdSel    <= fwdsel_d;
    end
  end

`ifdef ALUB_FWD_STATS_EN
  logic [15:0] ex_cnt;
  logic [15:0] wb_cnt;
  logic        count_en;

  assign count_en = load_en && in_valid && !ALUBSrc;

  // Saturating forward counters; only rst clears them
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_cnt <= '0;
      wb_cnt <= '0;
    end else if (count_en) begin
      if (ex_hit && (ex_cnt != 16'hFFFF)) begin
        ex_cnt <= ex_cnt + 16'd1;
      end
      if (!ex_hit && wb_hit && (wb_cnt != 16'hFFFF)) begin
        wb_cnt <= wb_cnt + 16'd1;
      end
    end
  end

  assign fwd_ex_cnt = ex_cnt;
  assign fwd_wb_cnt = wb_cnt;
`else
  logic unused_load_en;
  assign unused_load_en = load_en;
  assign fwd_ex_cnt     = 16'h0000;
  assign fwd_wb_cnt     = 16'h0000;
`endif

endmodule

// File: tb/tb_alub_fwd_stage.sv
// tb/tb_alub_fwd_stage.sv - scoreboard bench for alub_fwd_stage with randomized stimulus and reference model
module tb_alub_fwd_stage;

  typedef struct {
    logic        rst;
    logic        flush;
    logic        stall;
    logic        in_valid;
    logic        alubsrc;
    logic [31:0] imm;
    logic [31:0] rurs2;
    logic [4:0]  rs2a;
    logic [4:0]  exrd;
    logic        exwr;
    logic [31:0] exres;
    logic [4:0]  wbrd;
    logic        wbwr;
    logic [31:0] wbres;
  } stim_t;

  typedef struct {
    logic [31:0] b;
    logic [31:0] sd;
    logic        v;
    logic [1:0]  fs;
    logic [15:0] exc;
    logic [15:0] wbc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        ALUBSrc = 1'b0;
  logic [31:0] ImmExt = '0;
  logic [31:0] RUrs2 = '0;
  logic [4:0]  rs2_addr = '0;
  logic [4:0]  exmem_rd = '0;
  logic        exmem_RUWr = 1'b0;
  logic [31:0] exmem_result = '0;
  logic [4:0]  memwb_rd = '0;
  logic        memwb_RUWr = 1'b0;
  logic [31:0] memwb_result = '0;
  logic [31:0] B;
  logic [31:0] StoreData;
  logic        B_valid;
  logic [1:0]  FwdSel;
  logic [15:0] fwd_ex_cnt;
  logic [15:0] fwd_wb_cnt;

  int   total = 0;
  int   bad = 0;
  exp_t sb_q[$];
  exp_t m = '{b: '0, sd: '0, v: 1'b0, fs: 2'd0, exc: '0, wbc: '0};

  alub_fwd_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .ALUBSrc(ALUBSrc), .ImmExt(ImmExt), .RUrs2(RUrs2), .rs2_addr(rs2_addr),
    .exmem_rd(exmem_rd), .exmem_RUWr(exmem_RUWr), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_RUWr(memwb_RUWr), .memwb_result(memwb_result),
    .B(B), .StoreData(StoreData), .B_valid(B_valid), .FwdSel(FwdSel),
    .fwd_ex_cnt(fwd_ex_cnt), .fwd_wb_cnt(fwd_wb_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: what the register file would deliver for rs2 given in-flight writers
  function automatic void resolve(input stim_t s, output logic [31:0] val, output int src);
    val = s.rurs2;
    src = 0;
    if (s.rs2a != 0) begin
      if (s.exwr && s.exrd == s.rs2a) begin
        val = s.exres;
        src = 2;
      end else if (s.wbwr && s.wbrd == s.rs2a) begin
        val = s.wbres;
        src = 1;
      end
    end
  endfunction

  function automatic exp_t model_step(input exp_t cur, input stim_t s);
    exp_t        n;
    logic [31:0] val;
    int          src;
    n = cur;
    resolve(s, val, src);
    if (s.rst) begin
      n = '{b: '0, sd: '0, v: 1'b0, fs: 2'd0, exc: '0, wbc: '0};
    end else if (s.flush) begin
      n.b = 0; n.sd = 0; n.v = 0; n.fs = 0;
    end else if (!s.stall) begin
      n.sd = val;
      n.v  = s.in_valid;
      if (s.alubsrc) begin
        n.b  = s.imm;
        n.fs = 2'd3;
      end else begin
        n.b  = val;
        n.fs = 2'(src);
      end
`ifdef ALUB_FWD_STATS_EN
      if (s.in_valid && !s.alubsrc) begin
        if (src == 2 && n.exc != 16'hFFFF) n.exc = n.exc + 1;
        if (src == 1 && n.wbc != 16'hFFFF) n.wbc = n.wbc + 1;
      end
`endif
    end
    return n;
  endfunction

  task automatic apply(input stim_t s);
    @(negedge clk);
    rst = s.rst; flush = s.flush; stall = s.stall; in_valid = s.in_valid;
    ALUBSrc = s.alubsrc; ImmExt = s.imm; RUrs2 = s.rurs2; rs2_addr = s.rs2a;
    exmem_rd = s.exrd; exmem_RUWr = s.exwr; exmem_result = s.exres;
    memwb_rd = s.wbrd; memwb_RUWr = s.wbwr; memwb_result = s.wbres;
    m = model_step(m, s);
    sb_q.push_back(m);
  endtask

  function automatic stim_t base();
    stim_t s;
    s = '{rst: 0, flush: 0, stall: 0, in_valid: 1, alubsrc: 0, imm: '0, rurs2: '0,
          rs2a: '0, exrd: '0, exwr: 0, exres: '0, wbrd: '0, wbwr: 0, wbres: '0};
    return s;
  endfunction

  // Monitor: one expected entry per clock edge that followed a stimulus
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("B", B, e.b);
        chk("StoreData", StoreData, e.sd);
        chk("B_valid", {31'd0, B_valid}, {31'd0, e.v});
        chk("FwdSel", {30'd0, FwdSel}, {30'd0, e.fs});
        chk("fwd_ex_cnt", {16'd0, fwd_ex_cnt}, {16'd0, e.exc});
        chk("fwd_wb_cnt", {16'd0, fwd_wb_cnt}, {16'd0, e.wbc});
      end
    end
  end

  initial begin
    stim_t s;
    // reset two cycles
    s = base(); s.rst = 1; s.in_valid = 0;
    apply(s); apply(s);
    // basic select
    s = base(); s.rurs2 = 32'h10; s.imm = 32'h5;
    apply(s);
    s.alubsrc = 1;
    apply(s);
    // forward priority
    s = base(); s.rs2a = 7; s.exrd = 7; s.exwr = 1; s.exres = 32'hAAAA;
    s.wbrd = 7; s.wbwr = 1; s.wbres = 32'hBBBB;
    apply(s);
    s.exwr = 0;
    apply(s);
    // x0 guard
    s = base(); s.exrd = 0; s.exwr = 1; s.exres = 32'hDEAD; s.wbwr = 1; s.wbres = 32'hBEEF;
    apply(s);
    // store data alongside immediate
    s = base(); s.alubsrc = 1; s.imm = 32'hC; s.rs2a = 3; s.wbrd = 3; s.wbwr = 1; s.wbres = 32'h55;
    apply(s);
    // stall / flush / reset-in-stall
    s = base(); s.rurs2 = 32'h20;
    apply(s);
    for (int i = 0; i < 3; i++) begin
      s = base(); s.stall = 1; s.rurs2 = 32'h100 + i; s.imm = 32'h7; s.alubsrc = i[0];
      apply(s);
    end
    s = base(); s.stall = 1; s.flush = 1; s.rurs2 = 32'h99;
    apply(s);
    s = base(); s.rurs2 = 32'h31;
    apply(s);
    s.stall = 1; s.rst = 1;
    apply(s);
    // forward counting: 3 EX hits, 2 WB-only hits, a stalled hit, an invalid hit
    for (int i = 0; i < 3; i++) begin
      s = base(); s.rs2a = 5; s.exrd = 5; s.exwr = 1; s.exres = 32'h1000 + i;
      s.wbrd = 5; s.wbwr = i[0];
      apply(s);
    end
    for (int i = 0; i < 2; i++) begin
      s = base(); s.rs2a = 6; s.wbrd = 6; s.wbwr = 1; s.wbres = 32'h2000 + i;
      s.exrd = 9; s.exwr = 1;
      apply(s);
    end
    s = base(); s.stall = 1; s.rs2a = 5; s.exrd = 5; s.exwr = 1;
    apply(s);
    s = base(); s.in_valid = 0; s.rs2a = 5; s.exrd = 5; s.exwr = 1; s.exres = 32'h77;
    apply(s);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      s.rst      = ($urandom_range(0, 39) == 0);
      s.flush    = ($urandom_range(0, 9) == 0);
      s.stall    = ($urandom_range(0, 5) == 0);
      s.in_valid = $urandom_range(0, 1);
      s.alubsrc  = $urandom_range(0, 1);
      s.imm      = $urandom;
      s.rurs2    = $urandom;
      s.rs2a     = 5'($urandom_range(0, 3));
      s.exrd     = 5'($urandom_range(0, 3));
      s.exwr     = $urandom_range(0, 1);
      s.exres    = $urandom;
      s.wbrd     = 5'($urandom_range(0, 3));
      s.wbwr     = $urandom_range(0, 1);
      s.wbres    = $urandom;
      if ($urandom_range(0, 15) == 0) s.rs2a = 5'h1F;
      apply(s);
    end
`ifdef ALUB_FWD_STATS_EN
    // drive EX counter into saturation and past it
    s = base(); s.rst = 1;
    apply(s);
    s = base(); s.rs2a = 4; s.exrd = 4; s.exwr = 1; s.exres = 32'h4;
    for (int i = 0; i < 65537; i++) apply(s);
`endif
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
